// File: rtl/crossing_output_seq.sv
`default_nettype none
// ============================================================================
// Module   : crossing_output_seq
// Brief    : Level-crossing sequencer: road lamps, alarm and stepped barriers.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_output_seq #(
    parameter int N_BAR   = 2,
    parameter int T_WARN  = 8,
    parameter int T_AMBER = 4,
    parameter int T_STEP  = 3,
    parameter int CW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             approach,
    input  logic             clear,
    input  logic             maint,
    output logic             v,
    output logic             a,
    output logic             r,
    output logic             vint,
    output logic             al,
    output logic [N_BAR-1:0] b,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARN   = 3'd1,
        S_AMBER  = 3'd2,
        S_LOWER  = 3'd3,
        S_CLOSED = 3'd4,
        S_RAISE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] C_WARN_LAST  = CW'(T_WARN - 1);
    localparam logic [CW-1:0] C_AMBER_LAST = CW'(T_AMBER - 1);
    localparam logic [CW-1:0] C_STEP_LAST  = CW'(T_STEP - 1);

    state_t           r_state;
    logic [CW-1:0]    r_timer;
    logic [4:0]       r_lamps;  // {v, a, r, vint, al}
    logic [N_BAR-1:0] w_set;
    logic [N_BAR-1:0] w_drop;
    logic             w_found;
    logic             w_leave;

    // Lamp pattern owned by each state, registered together with the state.
    function automatic logic [4:0] lamps_of(input state_t s);
        case (s)
            S_IDLE:   lamps_of = 5'b10001;
            S_WARN:   lamps_of = 5'b00011;
            S_AMBER:  lamps_of = 5'b01000;
            S_LOWER:  lamps_of = 5'b00100;
            S_CLOSED: lamps_of = 5'b00100;
            S_RAISE:  lamps_of = 5'b00101;
            default:  lamps_of = 5'b10001;
        endcase
    endfunction

    // b + 1 flips the lowest clear bit to one; OR-ing keeps the rest.
    assign w_set   = b | (b + N_BAR'(1));
    assign w_leave = clear & ~approach;

    always_comb begin
        w_drop  = b;
        w_found = 1'b0;
        for (int i = N_BAR - 1; i >= 0; i--) begin
            if (b[i] && !w_found) begin
                w_drop[i] = 1'b0;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            b       <= '0;
            r_lamps <= lamps_of(S_IDLE);
        end else begin
            r_timer <= r_timer + CW'(1);
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (maint) begin
                        r_state <= S_LOWER;
                        r_lamps <= lamps_of(S_LOWER);
                    end else if (approach) begin
                        r_state <= S_WARN;
                        r_lamps <= lamps_of(S_WARN);
                    end
                end
                S_WARN: begin
                    if (maint) begin
                        r_state <= S_LOWER;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_LOWER);
                    end else if (w_leave) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_IDLE);
                    end else if (r_timer == C_WARN_LAST) begin
                        r_state <= S_AMBER;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_AMBER);
                    end
                end
                S_AMBER: begin
                    if (maint || (!w_leave && r_timer == C_AMBER_LAST)) begin
                        r_state <= S_LOWER;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_LOWER);
                    end else if (w_leave) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_IDLE);
                    end
                end
                S_LOWER: begin
                    if (r_timer == C_STEP_LAST) begin
                        r_timer <= '0;
                        b       <= w_set;
                        if (&w_set) begin
                            r_state <= S_CLOSED;
                            r_lamps <= lamps_of(S_CLOSED);
                        end
                    end
                end
                S_CLOSED: begin
                    r_timer <= '0;
                    if (w_leave && !maint) begin
                        r_state <= S_RAISE;
                        r_lamps <= lamps_of(S_RAISE);
                    end
                end
                S_RAISE: begin
                    // A returning train or maintenance resumes lowering from the current b.
                    if (approach || maint) begin
                        r_state <= S_LOWER;
                        r_timer <= '0;
                        r_lamps <= lamps_of(S_LOWER);
                    end else if (r_timer == C_STEP_LAST) begin
                        r_timer <= '0;
                        b       <= w_drop;
                        if (w_drop == '0) begin
                            r_state <= S_IDLE;
                            r_lamps <= lamps_of(S_IDLE);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    b       <= '0;
                    r_lamps <= lamps_of(S_IDLE);
                end
            endcase
        end
    end

    assign {v, a, r, vint, al} = r_lamps;
    assign state_o             = r_state;

endmodule
`default_nettype wire

// File: tb/tb_crossing_output_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossing_output_seq
// Brief    : Directed self-checking bench for crossing_output_seq (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossing_output_seq;

    logic       clk = 1'b0;
    logic       rst_n, approach, clear, maint;
    logic       v, a, r, vint, al;
    logic [1:0] b;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    crossing_output_seq dut (
        .clk(clk), .rst_n(rst_n), .approach(approach), .clear(clear), .maint(maint),
        .v(v), .a(a), .r(r), .vint(vint), .al(al), .b(b), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected {v, a, r, vint, al} for each state code.
    function automatic logic [4:0] lamps_exp(input int s);
        case (s)
            0:       lamps_exp = 5'b10001;
            1:       lamps_exp = 5'b00011;
            2:       lamps_exp = 5'b01000;
            3, 4:    lamps_exp = 5'b00100;
            5:       lamps_exp = 5'b00101;
            default: lamps_exp = 5'b10001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset at edge 0 with approach already high; edge 1 is the first live edge.
    task automatic start_seq();
        rst_n = 1'b0; approach = 1'b1; clear = 1'b0; maint = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; approach = 1'b1; clear = 1'b1; maint = 1'b1;
        tick(); tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_checks++;
        if ({v, a, r, vint, al} !== 5'b10001) begin n_fail++; $display("FAIL reset_lamps: got %b expected 10001", {v, a, r, vint, al}); end
        n_checks++;
        if (b !== 2'b00) begin n_fail++; $display("FAIL reset_b: got %b expected 00", b); end
    endtask

    task automatic test_full_cycle();
        int es;
        logic [1:0] eb;
        start_seq();
        for (int e = 1; e <= 22; e++) begin
            tick();
            es = (e < 9) ? 1 : (e < 13) ? 2 : (e < 19) ? 3 : 4;
            eb = (e < 16) ? 2'b00 : (e < 19) ? 2'b01 : 2'b11;
            n_checks++;
            if (state_o !== es[2:0]) begin n_fail++; $display("FAIL full_state e%0d: got %0d expected %0d", e, state_o, es); end
            n_checks++;
            if (b !== eb) begin n_fail++; $display("FAIL full_b e%0d: got %b expected %b", e, b, eb); end
            n_checks++;
            if ({v, a, r, vint, al} !== lamps_exp(es)) begin n_fail++; $display("FAIL full_lamps e%0d: got %b expected %b", e, {v, a, r, vint, al}, lamps_exp(es)); end
        end
    endtask

    // Continues from CLOSED left by test_full_cycle.
    task automatic test_raise();
        int es;
        logic [1:0] eb;
        approach = 1'b0; clear = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            es = (k < 6) ? 5 : 0;
            eb = (k < 3) ? 2'b11 : (k < 6) ? 2'b01 : 2'b00;
            n_checks++;
            if (state_o !== es[2:0]) begin n_fail++; $display("FAIL raise_state E+%0d: got %0d expected %0d", k, state_o, es); end
            n_checks++;
            if (b !== eb) begin n_fail++; $display("FAIL raise_b E+%0d: got %b expected %b", k, b, eb); end
            n_checks++;
            if ({v, a, r, vint, al} !== lamps_exp(es)) begin n_fail++; $display("FAIL raise_lamps E+%0d: got %b expected %b", k, {v, a, r, vint, al}, lamps_exp(es)); end
        end
    endtask

    task automatic test_reapproach();
        int es;
        logic [1:0] eb;
        start_seq();
        repeat (19) tick();
        approach = 1'b0; clear = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (b !== 2'b01 || state_o !== 3'd5) begin n_fail++; $display("FAIL reapp_pre: got b=%b st=%0d expected b=01 st=5", b, state_o); end
        approach = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            es = (k < 4) ? 3 : 4;
            eb = (k < 4) ? 2'b01 : 2'b11;
            n_checks++;
            if (state_o !== es[2:0]) begin n_fail++; $display("FAIL reapp_state k%0d: got %0d expected %0d", k, state_o, es); end
            n_checks++;
            if (b !== eb) begin n_fail++; $display("FAIL reapp_b k%0d: got %b expected %b", k, b, eb); end
        end
    endtask

    task automatic test_abort();
        start_seq();
        repeat (4) tick();
        n_checks++;
        if (state_o !== 3'd1) begin n_fail++; $display("FAIL abort_warn: got %0d expected 1", state_o); end
        approach = 1'b0; clear = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", state_o); end
        n_checks++;
        if ({v, vint, b} !== 4'b1000) begin n_fail++; $display("FAIL abort_out: got v=%b vint=%b b=%b expected v=1 vint=0 b=00", v, vint, b); end
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_hold: got %0d expected 0", state_o); end
    endtask

    task automatic test_maint();
        int es;
        logic [1:0] eb;
        rst_n = 1'b0; approach = 1'b0; clear = 1'b0; maint = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL maint_idle: got %0d expected 0", state_o); end
        maint = 1'b1; clear = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            es = (k < 6) ? 3 : 4;
            eb = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : 2'b11;
            n_checks++;
            if (state_o !== es[2:0]) begin n_fail++; $display("FAIL maint_state M+%0d: got %0d expected %0d", k, state_o, es); end
            n_checks++;
            if (b !== eb) begin n_fail++; $display("FAIL maint_b M+%0d: got %b expected %b", k, b, eb); end
        end
        maint = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 3'd5) begin n_fail++; $display("FAIL maint_release: got %0d expected 5", state_o); end
        repeat (3) tick();
        n_checks++;
        if (state_o !== 3'd5 || b !== 2'b01) begin n_fail++; $display("FAIL maint_raise_step: got st=%0d b=%b expected st=5 b=01", state_o, b); end
        maint = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 3'd3 || b !== 2'b01) begin n_fail++; $display("FAIL maint_in_raise: got st=%0d b=%b expected st=3 b=01", state_o, b); end
        repeat (3) tick();
        n_checks++;
        if (state_o !== 3'd4 || b !== 2'b11) begin n_fail++; $display("FAIL maint_reclose: got st=%0d b=%b expected st=4 b=11", state_o, b); end
        maint = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_seq();
        repeat (16) tick();
        n_checks++;
        if (state_o !== 3'd3 || b !== 2'b01) begin n_fail++; $display("FAIL rmid_pre: got st=%0d b=%b expected st=3 b=01", state_o, b); end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL rmid_state: got %0d expected 0", state_o); end
        n_checks++;
        if ({v, a, r, vint, al} !== 5'b10001 || b !== 2'b00) begin n_fail++; $display("FAIL rmid_out: got lamps=%b b=%b expected lamps=10001 b=00", {v, a, r, vint, al}, b); end
        tick();
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL rmid_hold: got %0d expected 0", state_o); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (state_o !== 3'd1) begin n_fail++; $display("FAIL rmid_release: got %0d expected 1", state_o); end
    endtask

    initial begin
        rst_n = 1'b0; approach = 1'b0; clear = 1'b0; maint = 1'b0;
        test_reset();
        test_full_cycle();
        test_raise();
        test_reapproach();
        test_abort();
        test_maint();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
